// File: rtl/chunked_add_sub.sv
// rtl/chunked_add_sub.sv - multi-cycle CHUNK-bit-per-cycle adder/subtractor with valid/ready handshake
module chunked_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_add_sub: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [CHUNK-1:0]   slice_a;
    logic [CHUNK-1:0]   slice_b;
    logic [CHUNK:0]     slice_res;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        slice_a   = a_q[int'(idx_q) * CHUNK +: CHUNK];
        slice_b   = b_q[int'(idx_q) * CHUNK +: CHUNK];
        slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d[int'(idx_q) * CHUNK +: CHUNK] = slice_res[CHUNK-1:0];
                carry_d = slice_res[CHUNK];
                if (idx_q == IDX_W'(N - 1)) begin
                    // a^b^s at the MSB recovers the carry into it; XOR with carry-out gives overflow
                    cout_d  = slice_res[CHUNK];
                    ovf_d   = slice_a[CHUNK-1] ^ slice_b[CHUNK-1]
                            ^ slice_res[CHUNK-1] ^ slice_res[CHUNK];
                    zero_d  = (sum_d == '0);
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: doc/chunked_add_sub.md
# chunked_add_sub

Parametrised multi-cycle adder/subtractor: adds or subtracts two WIDTH-bit operands CHUNK bits per clock through a carry register. It uses a CHUNK-bit full-adder ripple slice with a stored carry between slices. It sits behind a valid/ready handshake on both sides, so datapaths can trade latency for adder area. It also produces carry/borrow, signed-overflow and zero flags.

## Interface
- WIDTH, 16: operand/result width in bits; must be ≥1.
- CHUNK, 4: bits processed per cycle; WIDTH % CHUNK must be 0 (elaboration error otherwise).
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (subtract).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  add: carry out; subtract: 1 = no borrow, 0 = borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

## Operation
- N = WIDTH/CHUNK slices; slice i covers bits [i*CHUNK +: CHUNK].
- Accept occurs when in_valid && in_ready are high at a clk edge. On accept, the block latches a, b_eff = sub ? ~b : b, carry = sub ? ~cin : cin, and clears the slice index.
- Add result: a + b + cin. Subtract result: a − b − cin, computed as a + ~b + ~cin.
- FSM states:
  - IDLE: in_ready=1. Accept moves to BUSY.
  - BUSY: each cycle computes slice[idx] = a_slice + b_slice + carry. The slice is written into the sum register and its carry-out into the carry register; idx increments. After slice N−1 the FSM moves to DONE.
  - DONE: out_valid=1. out_ready moves to IDLE.
- Final cout = carry-out of slice N−1. ovf = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1). zero = (sum == 0). All three are registered together with the last slice.
- sum, cout, ovf and zero are valid only while out_valid=1. They are held stable in DONE regardless of input activity.
- in_valid and operand changes during BUSY/DONE are ignored; latched operands are not re-sampled.
- Unsigned wrap-around is natural modulo 2^WIDTH. No saturation.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, zero=0, idx=0, carry=0.
- Reset asserted mid-BUSY or mid-DONE aborts the operation; no result is emitted afterward.
- Latency: accept at edge k → out_valid high after edge k+N (N BUSY cycles). With CHUNK=WIDTH, out_valid is high after edge k+1.
- Result handshake at edge m (out_valid && out_ready) → IDLE after m, so in_ready=1 from m+1. Minimum initiation interval is N+2 cycles: one IDLE bubble between results.
- out_ready held low: DONE persists indefinitely, outputs stable, in_ready=0.
- out_ready high before out_valid has no effect.

## Test plan
- WIDTH=16, CHUNK=4, add 0x00FF + 0x0001, cin=0 → out_valid exactly 4 cycles after accept; sum=0x0100, cout=0, ovf=0, zero=0.
- Add 0xFFFF + 0x0001, cin=0 → sum=0x0000, cout=1, ovf=0, zero=1. Add 0x7FFF + 0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
- Subtract 0x0005 − 0x0007, cin=0 → sum=0xFFFE, cout=0 (borrow), ovf=0. Subtract 0x8000 − 0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure: out_ready=0 for 10 cycles in DONE while in_valid toggles with new operands → sum and flags unchanged, in_ready=0. out_ready=1 → in_ready=1 next cycle, and the next accept yields a fresh, correct result.
- Drop rst_n for 1 cycle during BUSY (slice 2 of 4) → immediately state=IDLE, out_valid=0, sum=0. The following operation 0x1234 + 0x4321 gives 0x5555.
- Regenerate with WIDTH=8, CHUNK=8 and WIDTH=32, CHUNK=1. Run 1000 random operations per configuration against a reference model → results and flags match; latencies are 1 and 32 cycles respectively.
